// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: 2:1 SRAM-like port arbiter that steers in-order responses back to their owners.
// Optional ARB_ROUND_ROBIN_EN alternates grants when both requesters are pending.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam logic [ID_W-1:0] MAX = ID_W'(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0] LAST = ID_W'(MAX_OUTSTANDING - 1);

    // Source id per outstanding transaction: 1 = data, 0 = inst
    logic [2**ID_W-1:0] order;
    logic [ID_W-1:0] head, tail, count;
    logic lock, lock_src, sel, push, pop;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr;
    assign sel = lock ? lock_src : (data_req & inst_req) ? ~rr : data_req;
`else
    assign sel = lock ? lock_src : data_req;
`endif

    assign mem_req = resetn & (sel ? data_req : inst_req) & (count < MAX);
    assign push = mem_req & mem_addr_ok;
    // Responses with nothing outstanding (spurious or from before a reset) are dropped
    assign pop = resetn & mem_data_ok & (count != '0);

    assign inst_addr_ok = push & ~sel;
    assign data_addr_ok = push & sel;
    assign inst_data_ok = pop & ~order[head];
    assign data_data_ok = pop & order[head];
    assign inst_rdata = resetn ? mem_rdata : '0;
    assign data_rdata = resetn ? mem_rdata : '0;

    assign mem_wr = resetn & (sel ? data_wr : inst_wr);
    assign mem_size = resetn ? (sel ? data_size : inst_size) : '0;
    assign mem_wstrb = resetn ? (sel ? data_wstrb : inst_wstrb) : '0;
    assign mem_addr = resetn ? (sel ? data_addr : inst_addr) : '0;
    assign mem_wdata = resetn ? (sel ? data_wdata : inst_wdata) : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            order <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            lock <= 1'b0;
            lock_src <= 1'b0;
        end else begin
            if (push) begin
                order[tail] <= sel;
                tail <= (tail == LAST) ? '0 : tail + ID_W'(1);
            end
            if (pop)
                head <= (head == LAST) ? '0 : head + ID_W'(1);
            count <= count + ID_W'(push) - ID_W'(pop);
            lock <= mem_req & ~mem_addr_ok;
            lock_src <= sel;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!resetn)
            rr <= 1'b1;
        else if (push)
            rr <= sel;
    end
`endif

    spurious_response: assert property (@(posedge clk) disable iff (!resetn) !(mem_data_ok && count == '0))
        else $warning("mem_data_ok with no outstanding transaction dropped");
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed and random stimulus checked against a queue-based ownership model.
module tb_sram_like_arbiter;
    localparam int MAXO = 2;

    logic clk = 0, resetn = 0;
    logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0] inst_size = 0, data_size = 0;
    logic [3:0] inst_wstrb = 0, data_wstrb = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic mem_addr_ok = 0, mem_data_ok = 0;
    logic [31:0] mem_rdata = 0;
    logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, mem_wr;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [1:0] mem_size;
    logic [3:0] mem_wstrb;

    int checks = 0, errors = 0;
    bit owners[$];
    bit held = 0, held_src = 0, last = 1;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(MAXO), .ID_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply downstream inputs after negedge, check, advance model at posedge.
    task automatic cycle(input bit aok, input bit dok, input logic [31:0] rd);
        bit g, mreq, hs, resp;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata = rd;
        #1;
        if (held) g = held_src;
`ifdef ARB_ROUND_ROBIN_EN
        else if (inst_req && data_req) g = !last;
`endif
        else g = data_req;
        mreq = (g ? data_req : inst_req) && owners.size() < MAXO;
        hs = mreq && aok;
        resp = dok && owners.size() > 0;
        check("mem_req", mem_req, mreq);
        check("inst_addr_ok", inst_addr_ok, hs && !g);
        check("data_addr_ok", data_addr_ok, hs && g);
        check("inst_data_ok", inst_data_ok, resp && !owners[0]);
        check("data_data_ok", data_data_ok, resp && owners[0]);
        if (resp) check("rdata", owners[0] ? data_rdata : inst_rdata, rd);
        if (mreq) begin
            check("mem_addr", mem_addr, g ? data_addr : inst_addr);
            check("mem_wdata", mem_wdata, g ? data_wdata : inst_wdata);
            check("mem_ctl", {mem_wr, mem_size, mem_wstrb},
                  g ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
        end
        @(posedge clk);
        if (resp) void'(owners.pop_front());
        if (hs) begin
            owners.push_back(g);
            last = g;
        end
        held = mreq && !aok;
        held_src = g;
        #1;
        if (hs && g) data_req = 0;
        if (hs && !g) inst_req = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 0;
        inst_req = 1;
        data_req = 1;
        mem_addr_ok = 1;
        mem_data_ok = 1;
        mem_rdata = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        check("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        check("rst_rdata", inst_rdata | data_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        inst_req = 0;
        data_req = 0;
        mem_addr_ok = 0;
        mem_data_ok = 0;
        resetn = 1;
        owners.delete();
        held = 0;
        last = 1;
        cycle(1, 0, 0);
    endtask

    task automatic inst_read(input logic [31:0] a);
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_wstrb = 4'hF; inst_addr = a; inst_wdata = 0;
    endtask

    task automatic data_op(input bit w, input logic [31:0] a, input logic [31:0] d);
        data_req = 1; data_wr = w; data_size = 2; data_wstrb = 4'hF; data_addr = a; data_wdata = d;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // single inst read
        inst_read(32'h1C00_0000);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 32'h0280_0000);
        // contention, then in-order responses A then B
        inst_read(32'h1C00_0010);
        data_op(0, 32'h1C00_4000, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 32'hAAAA_0001);
        cycle(0, 1, 32'hBBBB_0002);
        // lock: data write stalled, inst rises during stall
        data_op(1, 32'h1C00_8000, 32'h1234_5678);
        cycle(0, 0, 0);
        inst_read(32'h1C00_0020);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 32'h0000_0011);
        cycle(0, 1, 32'h0000_0022);
        // full, then resume the cycle after a pop
        inst_read(32'h1C00_0100);
        cycle(1, 0, 0);
        inst_read(32'h1C00_0104);
        cycle(1, 0, 0);
        inst_read(32'h1C00_0108);
        cycle(1, 0, 0);
        cycle(1, 1, 32'h0000_0033);
        cycle(1, 0, 0);
        cycle(0, 1, 32'h0000_0044);
        // simultaneous push and pop at one outstanding
        cycle(0, 0, 0);
        data_op(0, 32'h1C00_C000, 0);
        cycle(1, 1, 32'h0000_0055);
        cycle(0, 1, 32'h0000_0066);
        // spurious response with nothing outstanding
        cycle(0, 1, 32'hDEAD_BEEF);
        // reset mid-transaction, late response dropped
        data_op(0, 32'h1C00_D000, 0);
        cycle(1, 0, 0);
        do_reset();
        cycle(0, 1, 32'h0BAD_0BAD);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!inst_req && $urandom_range(0, 2) == 0) inst_read($urandom);
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_op(1'($urandom_range(0, 1)), $urandom, $urandom);
                data_size = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom);
            end
            cycle(1'($urandom_range(0, 1)), owners.size() > 0 && $urandom_range(0, 2) == 0, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
